uart_peek_initiator: RTL and testbench
======================================

UART_PEEK_INITIATOR -- requirements
Module: uart_peek_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: max idle clk cycles between response bytes before abort.
REQ-002 SHALL have parameter ID_W, default 8: significant width of req_id; upper bits of the id byte are sent as 0.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  peek request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_addr  in  32  peek address.
REQ-008 req_id  in  ID_W  target core id.
REQ-009 tx_data  out  8  byte to UART transmitter.
REQ-010 tx_valid  out  1  tx_data valid.
REQ-011 tx_ready  in  1  UART transmitter accepts byte this cycle.
REQ-012 rx_data  in  8  byte from UART receiver.
REQ-013 rx_valid  in  1  one-cycle strobe per received byte.
REQ-014 resp_valid  out  1  one-cycle pulse: resp_data updated.
REQ-015 resp_data  out  32  last completed peek word.
REQ-016 resp_timeout  out  1  one-cycle pulse: response aborted.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 rx_drop_cnt  out  8  saturating count of rx bytes ignored.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, WAIT_RESP.
REQ-020 IDLE: req_ready=1, tx_valid=0; on req_valid, latch req_addr and zero-extended req_id, clear byte counter, go to SEND.
REQ-021 Request frame SHALL be 5 bytes: addr[7:0], addr[15:8], addr[23:16], addr[31:24], id byte, in that order.
REQ-022 SEND: tx_valid=1, tx_data = frame byte at byte counter; byte advances only on a cycle with tx_valid && tx_ready.
REQ-023 tx_data SHALL remain stable while tx_valid=1 and tx_ready=0; tx_valid SHALL NOT drop mid-frame.
REQ-024 First tx_valid SHALL appear the cycle after request acceptance; with tx_ready held 1, the frame takes exactly 5 cycles.
REQ-025 On acceptance of byte 4 (id), SHALL go to WAIT_RESP with rx byte counter=0 and timer=0.
REQ-026 WAIT_RESP: each rx_valid byte k (0..3) SHALL be stored to response bits [8k+7:8k] (LSB first); timer cleared on each byte.
REQ-027 On the 4th byte, resp_data SHALL update and resp_valid SHALL pulse high for exactly the next cycle; FSM returns to IDLE that same cycle.
REQ-028 resp_data SHALL hold its value until the next successful response; partial captures SHALL NOT be visible on resp_data.
REQ-029 Timer SHALL increment each WAIT_RESP cycle without rx_valid; at TIMEOUT_CYCLES-1 SHALL pulse resp_timeout one cycle, discard partial bytes, go to IDLE.
REQ-030 rx_valid in IDLE or SEND SHALL be ignored and increment rx_drop_cnt, saturating at 255.
REQ-031 req_valid while busy=1 SHALL be ignored (req_ready=0); no queueing.
REQ-032 A request presented in the cycle resp_valid or resp_timeout pulses SHALL be accepted (FSM already IDLE).
REQ-033 rx_valid coinciding with the timeout-expiry cycle SHALL count as a byte and cancel the timeout.

Reset
REQ-034 On rst: state IDLE, req_ready=1, tx_valid=0, tx_data=0, resp_valid=0, resp_timeout=0, resp_data=0, busy=0, rx_drop_cnt=0, all counters/timers 0.
REQ-035 rst asserted mid-frame or mid-response SHALL abort immediately with no further tx_valid and no resp pulse.

Verification
REQ-036 req addr=0x12345678, id=0x03, tx_ready=1 -> tx bytes 78,56,34,12,03 over 5 consecutive cycles; busy=1.
REQ-037 After the frame, rx bytes EF,BE,AD,DE -> resp_data=0xDEADBEEF, resp_valid one-cycle pulse, req_ready=1.
REQ-038 tx_ready toggling 1,0,0,1,... -> byte order unchanged, tx_data stable during stalls, no byte duplicated or skipped.
REQ-039 TIMEOUT_CYCLES=16, only 2 rx bytes returned -> resp_timeout pulses 15 cycles after the 2nd byte; resp_data keeps the previous value.
REQ-040 3 rx_valid strobes in IDLE -> rx_drop_cnt=3, no resp_valid; 300 strobes -> rx_drop_cnt=255.
REQ-041 rst pulsed after byte 2 sent -> all outputs at reset values; a new request afterwards sends a full 5-byte frame.

Source files
------------

// File: rtl/uart_peek_initiator.sv
// uart_peek_initiator: sends a 5-byte peek frame over a UART byte stream and
// collects the 4-byte little-endian reply, with an inter-byte timeout.
module uart_peek_initiator #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int ID_W           = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_addr,
    input  logic [ID_W-1:0] req_id,
    output logic [7:0]      tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            resp_valid,
    output logic [31:0]     resp_data,
    output logic            resp_timeout,
    output logic            busy,
    output logic [7:0]      rx_drop_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_id;
    logic [2:0]  r_byte;
    logic [1:0]  r_rx_cnt;
    logic [23:0] r_buf;
    logic [31:0] r_timer;
    logic [31:0] r_resp_data;
    logic        r_resp_valid;
    logic        r_resp_timeout;
    logic [7:0]  r_drop;

    assign req_ready    = r_state == IDLE;
    assign busy         = r_state != IDLE;
    assign tx_valid     = r_state == SEND;
    assign resp_valid   = r_resp_valid;
    assign resp_timeout = r_resp_timeout;
    assign resp_data    = r_resp_data;
    assign rx_drop_cnt  = r_drop;
    assign tx_data      = r_state != SEND  ? 8'h00 :
                          r_byte == 3'd0   ? r_addr[7:0] :
                          r_byte == 3'd1   ? r_addr[15:8] :
                          r_byte == 3'd2   ? r_addr[23:16] :
                          r_byte == 3'd3   ? r_addr[31:24] : r_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_id           <= '0;
            r_byte         <= '0;
            r_rx_cnt       <= '0;
            r_buf          <= '0;
            r_timer        <= '0;
            r_resp_data    <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_drop         <= '0;
        end else begin
            r_resp_valid   <= 1'b0;
            r_resp_timeout <= 1'b0;
            if (rx_valid && r_state != WAIT_RESP && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
            case (r_state)
                IDLE: if (req_valid) begin
                    r_addr  <= req_addr;
                    r_id    <= 8'(req_id);
                    r_byte  <= '0;
                    r_state <= SEND;
                end
                SEND: if (tx_ready) begin
                    if (r_byte == 3'd4) begin
                        r_state  <= WAIT_RESP;
                        r_rx_cnt <= '0;
                        r_timer  <= '0;
                    end else begin
                        r_byte <= r_byte + 3'd1;
                    end
                end
                WAIT_RESP: if (rx_valid) begin
                    // bytes arrive LSB first: shift down so byte 0 ends at bits [7:0]
                    r_timer  <= '0;
                    r_rx_cnt <= r_rx_cnt + 2'd1;
                    r_buf    <= {rx_data, r_buf[23:8]};
                    if (r_rx_cnt == 2'd3) begin
                        r_resp_data  <= {rx_data, r_buf};
                        r_resp_valid <= 1'b1;
                        r_state      <= IDLE;
                    end
                end else if (r_timer == 32'(TIMEOUT_CYCLES - 2)) begin
                    r_resp_timeout <= 1'b1;
                    r_state        <= IDLE;
                end else begin
                    r_timer <= r_timer + 32'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_peek_initiator.sv
// tb_uart_peek_initiator: randomized peek traffic against a queue-based
// reference model; a negedge monitor scores every tx byte and response pulse.
module tb_uart_peek_initiator;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_id;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_timeout;
    logic        busy;
    logic [7:0]  rx_drop_cnt;

    uart_peek_initiator #(.TIMEOUT_CYCLES(TO), .ID_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_id(req_id), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout),
        .busy(busy), .rx_drop_cnt(rx_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {bit to; logic [31:0] val;} resp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_tx[$];
    resp_t       exp_resp[$];
    logic [31:0] last_resp = 32'h0;
    int          drop_model = 0;
    int          tx_mode = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // tx_ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
    initial begin
        int pcnt = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pcnt++;
            tx_ready = tx_mode == 0 ? 1'b1 : tx_mode == 1 ? (pcnt % 3 == 0) : 1'($urandom % 2);
        end
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h0;
    logic       prev_rv = 1'b0;
    resp_t      mr;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_rv    <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
                end else begin
                    checks--;
                    chk("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
            end
            if (resp_valid) begin
                chk("resp_pulse_width", 32'(prev_rv), 32'd0);
                chk("resp_req_ready", 32'(req_ready), 32'd1);
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got resp_valid data %h expected none", resp_data);
                end else begin
                    mr = exp_resp.pop_front();
                    chk("resp_kind_data", 32'(mr.to), 32'd0);
                    chk("resp_data", resp_data, mr.val);
                end
            end
            if (resp_timeout) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout_unexpected: got resp_timeout expected none");
                end else begin
                    mr = exp_resp.pop_front();
                    chk("resp_kind_timeout", 32'(mr.to), 32'd1);
                    chk("timeout_keeps_data", resp_data, mr.val);
                end
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
            prev_rv    <= resp_valid;
        end
    end

    // nb = number of reply bytes returned (4 = complete, fewer = timeout)
    task automatic peek(input logic [31:0] addr, input logic [7:0] id,
                        input logic [31:0] val, input int nb, input int mode);
        int n;
        tx_mode = mode;
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'(addr >> (8 * i)));
        exp_tx.push_back(id);
        if (nb == 4) begin
            exp_resp.push_back('{1'b0, val});
            last_resp = val;
        end else begin
            exp_resp.push_back('{1'b1, last_resp});
        end
        req_addr  = addr;
        req_id    = id;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("first_tx_valid", 32'(tx_valid), 32'd1);
        chk("busy_in_frame", 32'(busy), 32'd1);
        n = 0;
        while (tx_valid && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (mode == 0) chk("frame_cycles", 32'(n), 32'd5);
        chk("frame_done", 32'(tx_valid), 32'd0);
        chk("busy_wait_resp", 32'(busy), 32'd1);
        for (int k = 0; k < nb; k++) begin
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk);
                #1 req_valid = 1'($urandom % 2);
                req_addr = $urandom;
            end
            @(posedge clk);
            #1 req_valid = 1'b0;
            rx_data  = 8'(val >> (8 * k));
            rx_valid = 1'b1;
            @(posedge clk);
            #1 rx_valid = 1'b0;
            rx_data = 8'($urandom);
        end
        if (nb < 4) begin
            n = 0;
            do begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end while (!resp_timeout && n < 200);
            chk("timeout_seen", 32'(resp_timeout), 32'd1);
            if (nb > 0) chk("timeout_gap", 32'(n), 32'(TO - 1));
        end
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx_valid = 1'b1;
            rx_data = 8'($urandom);
            drop_model++;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
        chk("rx_drop_cnt", 32'(rx_drop_cnt), 32'(drop_model > 255 ? 255 : drop_model));
    endtask

    task automatic check_reset_values();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(rx_drop_cnt), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_id = '0;
        rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        peek(32'h12345678, 8'h03, 32'hDEADBEEF, 4, 0);
        peek(32'hA5C3_0F81, 8'h7E, 32'hCAFEF00D, 4, 1);
        peek(32'h0BAD_CAFE, 8'h11, 32'h01020304, 2, 0);
        strobes(3);

        tx_mode = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'(32'h55AA_1234 >> (8 * i)));
        exp_tx.push_back(8'h42);
        req_addr = 32'h55AA_1234; req_id = 8'h42; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_values();
        chk("frame_bytes_left_at_rst", 32'(exp_tx.size()), 32'd2);
        exp_tx.delete();
        drop_model = 0;
        last_resp  = 32'h0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_rst", 32'(tx_valid), 32'd0);
        end
        peek(32'h89AB_CDEF, 8'h05, 32'h600D_F00D, 4, 0);

        for (int t = 0; t < 24; t++) begin
            nb = ($urandom % 4 == 0) ? int'($urandom % 4) : 4;
            peek($urandom, 8'($urandom), $urandom, nb, int'($urandom % 3));
            if ($urandom % 3 == 0) strobes(int'($urandom_range(1, 3)));
        end
        strobes(300);

        repeat (5) @(negedge clk);
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
